uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter driven by the system clock, with an internal bit-period counter, so no external baud clock is needed. Data width, parity mode, stop-bit count and bit period are configurable.
A small FIFO with a valid/ready write interface buffers words, and frames go out back-to-back.
Sits between the host-side datapath and the serial pin, as the next-generation TX path.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
CLKS_PER_BIT, 868, system clocks per serial bit; legal >= 2
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 4, buffered words; power of two, >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
tx_data  input  DATA_BITS  word to send, LSB transmitted first
tx_valid  input  1  tx_data is valid
tx_ready  output  1  FIFO can accept a word; equals !fifo_full
tx_out  output  1  serial line (registered), idle high
tx_busy  output  1  high when state != IDLE or FIFO not empty

Behaviour:
- Reset (async, active-high):
  - tx_out=1, state=IDLE, baud counter=0, bit index=0.
  - FIFO flushed (count=0), so tx_ready=1 and tx_busy=0.
  - Asserting rst mid-frame aborts the frame immediately; tx_out returns high without waiting for a clock edge.
- Write: a word is accepted at the rising edge where tx_valid && tx_ready.
  - When full, a write is refused even if a pop occurs on the same edge; no full-bypass.
- States: IDLE, START, DATA, PARITY, STOP.
  - Each bit holds tx_out for exactly CLKS_PER_BIT clocks.
  - Baud counter runs 0..CLKS_PER_BIT-1; width is clog2(CLKS_PER_BIT).
  - The state/bit advances on the edge where the counter equals CLKS_PER_BIT-1, and the counter then returns to 0.
- IDLE:
  - tx_out=1.
  - On an edge with FIFO non-empty: pop the head into the shift register, tx_out<=0, go to START.
  - Popping uses the FIFO state before the edge, so there is no write-to-pop bypass.
  - A word written at edge N into an empty FIFO drives tx_out low from edge N+1.
- START: after one bit period, go to DATA with tx_out<=shreg[0].
- DATA:
  - Shift out LSB first for DATA_BITS bit periods.
  - After the last data bit, go to PARITY if PARITY!=0, otherwise go to STOP.
- PARITY:
  - Even: bit = XOR of the data word. Odd: bit = inverted XOR of the data word.
  - Computed from the word latched at pop, not from live tx_data.
  - Lasts one bit period.
- STOP:
  - tx_out=1 for STOP_BITS bit periods.
  - On the final edge: if FIFO non-empty, pop, tx_out<=0, go to START (no idle gap); otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT clocks.
- tx_out only changes on bit boundaries; it is glitch-free because it is registered.
- Illegal parameter values are rejected at elaboration (generate-time check), not at runtime.

Decomposition:
- Package uart_pkg:
  - state encoding for IDLE/START/DATA/PARITY/STOP
  - PARITY_NONE/ODD/EVEN constants
  - clog2 helper
- One sub-module: uart_tx_fifo.
  - Synchronous FIFO with async reset.
  - Parameters WIDTH, DEPTH.
  - Ports wr_en, wr_data, rd_en, rd_data, full, empty.
  - Read data is available combinationally from the head.
- The top level holds the baud counter, shift register, bit index and FSM.

Test Plan:
- 8N1, CLKS_PER_BIT=4; write 0xA5 at edge 0 -> tx_out low from edge 1 for 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, then high for 4 clks; tx_busy falls after 40 clks.
- PARITY=2 (even), DATA_BITS=8; send 0x07 -> parity bit 1. PARITY=1 (odd); send 0x07 -> parity bit 0. Frame is 44 clks.
- STOP_BITS=2, DATA_BITS=7; send 0x7F -> start, seven 1s, then stop high for 8 clks; total 40 clks at CLKS_PER_BIT=4.
- FIFO_DEPTH=4 with tx_valid held high and words 0x01..0x06:
  - Five words are accepted at edges 0..4; tx_ready is low from edge 5.
  - tx_ready rises one clk after the second frame's start pop.
  - Frames 0x01..0x05 go out with no idle gap between stop and start.
- Reset asserted mid-DATA of 0x3C with two words queued -> tx_out=1 immediately; tx_busy=0, tx_ready=1; no further frames after reset release.
- Write on the same edge as the last stop-bit edge with the FIFO previously empty -> FSM goes to IDLE; START begins one clk later (no bypass).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Ceiling log2, clamped to at least 1 so it is always usable as a width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO; the head word is visible combinationally on rd_data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_wr, do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with an internal bit-period counter and a buffered write port.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy
);
    localparam int CW = clog2(CLKS_PER_BIT);
    localparam int BW = clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
        PARITY < PARITY_NONE || PARITY > PARITY_EVEN ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_param: illegal parameter value");
    end

    tx_state_e            state_q;
    logic [CW-1:0]        baud_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_q;
    logic                 tx_q;

    logic [DATA_BITS-1:0] head;
    logic                 fifo_full, fifo_empty;
    logic                 bit_end, pop, par_d;

    uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bit_end  = (baud_q == BAUD_LAST);
    assign par_d    = (^head) ^ (PARITY == PARITY_ODD);
    assign tx_ready = !fifo_full;
    assign tx_out   = tx_q;
    assign tx_busy  = (state_q != S_IDLE) || !fifo_empty;

    // Pop from IDLE immediately, or at the close of the last stop bit for gapless frames.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state_q == S_IDLE) pop = 1'b1;
            else if (state_q == S_STOP && bit_end && bit_q == STOP_LAST) pop = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else if (state_q == S_IDLE) begin
            tx_q   <= 1'b1;
            baud_q <= '0;
            if (pop) begin
                shreg_q <= head;
                par_q   <= par_d;
                tx_q    <= 1'b0;
                bit_q   <= '0;
                state_q <= S_START;
            end
        end else if (!bit_end) begin
            baud_q <= baud_q + 1'b1;
        end else begin
            baud_q <= '0;
            case (state_q)
                S_START: begin
                    tx_q    <= shreg_q[0];
                    shreg_q <= {1'b0, shreg_q[DATA_BITS-1:1]};
                    bit_q   <= '0;
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (bit_q == DATA_LAST) begin
                        bit_q <= '0;
                        if (PARITY != PARITY_NONE) begin
                            tx_q    <= par_q;
                            state_q <= S_PARITY;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end
                    end else begin
                        bit_q   <= bit_q + 1'b1;
                        tx_q    <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[DATA_BITS-1:1]};
                    end
                end
                S_PARITY: begin
                    tx_q    <= 1'b1;
                    bit_q   <= '0;
                    state_q <= S_STOP;
                end
                S_STOP: begin
                    if (bit_q != STOP_LAST) begin
                        bit_q <= bit_q + 1'b1;
                    end else if (pop) begin
                        shreg_q <= head;
                        par_q   <= par_d;
                        tx_q    <= 1'b0;
                        bit_q   <= '0;
                        state_q <= S_START;
                    end else begin
                        tx_q    <= 1'b1;
                        bit_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param across four parameter sets sharing one clock and reset.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [8:0] din;
    logic [3:0] txo, rdy, bsy;
    logic [1:0] sel;
    logic       to_m, rdy_m, bsy_m;
    logic       exp_q [$];
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    assign to_m  = txo[sel];
    assign rdy_m = rdy[sel];
    assign bsy_m = bsy[sel];

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2 -- all at 4 clocks per bit
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .tx_data(din[7:0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_out(txo[0]), .tx_busy(bsy[0]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .tx_data(din[7:0]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_out(txo[1]), .tx_busy(bsy[1]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .tx_data(din[7:0]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_out(txo[2]), .tx_busy(bsy[2]));
    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .tx_data(din[6:0]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx_out(txo[3]), .tx_busy(bsy[3]));

    // Expected line level per clock, four clocks per bit.
    function automatic void push_bit(input logic b);
        for (int k = 0; k < 4; k++) exp_q.push_back(b);
    endfunction

    function automatic void add_frame(input logic [8:0] w, input int nb, input int par, input int sb);
        logic p;
        p = 1'b0;
        push_bit(1'b0);
        for (int i = 0; i < nb; i++) begin
            push_bit(w[i]);
            p = p ^ w[i];
        end
        if (par == 1) push_bit(~p);
        if (par == 2) push_bit(p);
        for (int s = 0; s < sb; s++) push_bit(1'b1);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        vld = '0;
        din = '0;
        sel = 2'd0;
        #1;
        nvec++;
        if (txo !== 4'hF || rdy !== 4'hF || bsy !== 4'h0) begin
            nerr++;
            $display("FAIL reset_state: tx_out=%b ready=%b busy=%b want 1111 1111 0000", txo, rdy, bsy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_frame(input string name, input logic [1:0] s, input logic [8:0] w,
                             input int nb, input int par, input int sb);
        exp_q.delete();
        add_frame(w, nb, par, sb);
        sel = s;
        @(negedge clk);
        din = w;
        vld[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[s] = 1'b0;
        nvec++;
        if (to_m !== 1'b1 || bsy_m !== 1'b1) begin
            nerr++;
            $display("FAIL %s_pre_start: tx_out=%b busy=%b want 1 1", name, to_m, bsy_m);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            nvec++;
            if (to_m !== exp_q[i] || bsy_m !== 1'b1) begin
                nerr++;
                $display("FAIL %s clk %0d: tx_out=%b busy=%b want %b 1", name, i, to_m, bsy_m, exp_q[i]);
            end
        end
        @(negedge clk);
        nvec++;
        if (to_m !== 1'b1 || bsy_m !== 1'b0) begin
            nerr++;
            $display("FAIL %s_end: tx_out=%b busy=%b want 1 0", name, to_m, bsy_m);
        end
    endtask

    task automatic test_8n1();
        run_frame("8n1_a5", 2'd0, 9'h0A5, 8, 0, 1);
    endtask

    task automatic test_parity();
        run_frame("even_07", 2'd1, 9'h007, 8, 2, 1);
        run_frame("odd_07", 2'd2, 9'h007, 8, 1, 1);
    endtask

    task automatic test_two_stop();
        run_frame("7n2_7f", 2'd3, 9'h07F, 7, 0, 2);
    endtask

    task automatic test_back_to_back();
        int  cnt, acc, pops, t;
        logic rdy_exp, e_line, a, p;
        exp_q.delete();
        for (int w = 1; w <= 6; w++) add_frame(9'(w), 8, 0, 1);
        sel = 2'd0;
        cnt = 0;
        acc = 0;
        pops = 0;
        for (int e = 0; e < 250; e++) begin
            @(negedge clk);
            if (e >= 1) begin
                t = e - 1;
                e_line = (t == 0 || t - 1 >= exp_q.size()) ? 1'b1 : exp_q[t-1];
                nvec++;
                if (to_m !== e_line) begin
                    nerr++;
                    $display("FAIL b2b_line after edge %0d: tx_out=%b want %b", t, to_m, e_line);
                end
            end
            rdy_exp = (cnt < 4);
            nvec++;
            if (rdy_m !== rdy_exp) begin
                nerr++;
                $display("FAIL b2b_ready before edge %0d: tx_ready=%b want %b", e, rdy_m, rdy_exp);
            end
            vld[0] = (acc < 6);
            din = 9'(acc + 1);
            @(posedge clk);
            a = vld[0] && rdy_exp;
            p = (cnt > 0) && (pops < 6) && (e == 1 + 40 * pops);
            if (p) pops++;
            cnt = cnt + int'(a) - int'(p);
            acc = acc + int'(a);
        end
        vld[0] = 1'b0;
        @(negedge clk);
        nvec++;
        if (bsy_m !== 1'b0 || rdy_m !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_end: busy=%b ready=%b want 0 1", bsy_m, rdy_m);
        end
    endtask

    task automatic test_reset_midframe();
        logic [8:0] words [3];
        words[0] = 9'h03C;
        words[1] = 9'h011;
        words[2] = 9'h022;
        sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din = words[i];
            vld[0] = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (4) @(negedge clk);
        nvec++;
        if (to_m !== 1'b0 || bsy_m !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid_pre: tx_out=%b busy=%b want 0 1", to_m, bsy_m);
        end
        #1 rst = 1'b1;
        #1;
        nvec++;
        if (to_m !== 1'b1 || bsy_m !== 1'b0 || rdy_m !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid_async: tx_out=%b busy=%b ready=%b want 1 0 1", to_m, bsy_m, rdy_m);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            nvec++;
            if (to_m !== 1'b1 || bsy_m !== 1'b0) begin
                nerr++;
                $display("FAIL rst_mid_after clk %0d: tx_out=%b busy=%b want 1 0", i, to_m, bsy_m);
            end
        end
    endtask

    task automatic test_no_bypass();
        sel = 2'd0;
        @(negedge clk);
        din = 9'h05A;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (40) @(negedge clk);
        nvec++;
        if (to_m !== 1'b1 || bsy_m !== 1'b1) begin
            nerr++;
            $display("FAIL nobyp_stop: tx_out=%b busy=%b want 1 1", to_m, bsy_m);
        end
        din = 9'h081;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        nvec++;
        if (to_m !== 1'b1 || bsy_m !== 1'b1) begin
            nerr++;
            $display("FAIL nobyp_idle: tx_out=%b busy=%b want 1 1", to_m, bsy_m);
        end
        @(negedge clk);
        nvec++;
        if (to_m !== 1'b0) begin
            nerr++;
            $display("FAIL nobyp_start: tx_out=%b want 0", to_m);
        end
        repeat (45) @(negedge clk);
        nvec++;
        if (to_m !== 1'b1 || bsy_m !== 1'b0) begin
            nerr++;
            $display("FAIL nobyp_end: tx_out=%b busy=%b want 1 0", to_m, bsy_m);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_midframe();
        test_no_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
